// File: rtl/bidir_normalizer.sv
// bidir_normalizer: multi-cycle normalizer that shifts an operand one bit per
// clock toward its leading (dir=0) or trailing (dir=1) one, and reports the
// normalized value together with the number of single-bit shifts applied.
// The shift count it reports is exactly what the companion barrel shifter
// consumes to undo or reproduce the normalization.
module bidir_normalizer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3     // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic [CNT_W-1:0] shamt,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] data_reg;
    logic             dir_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] out_reg;
    logic [CNT_W-1:0] shamt_reg;
    logic             zero_reg;

    // The bit that terminates the search: MSB when normalizing left, LSB when
    // normalizing right. A nonzero operand always reaches it within WIDTH-1
    // shifts, so the count can never wrap.
    logic hit;
    assign hit = dir_reg ? data_reg[0] : data_reg[WIDTH-1];

    // Control FSM, working shift register and result registers. Results are
    // written only on entry to DONE so intermediate shift values never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            dir_reg   <= 1'b0;
            count_reg <= '0;
            out_reg   <= '0;
            shamt_reg <= '0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (in == '0) begin
                            // Nothing to search for: finish immediately.
                            out_reg   <= '0;
                            shamt_reg <= '0;
                            zero_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            data_reg  <= in;
                            dir_reg   <= dir;
                            count_reg <= '0;
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (hit) begin
                        out_reg   <= data_reg;
                        shamt_reg <= count_reg;
                        zero_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        data_reg  <= dir_reg ? (data_reg >> 1) : (data_reg << 1);
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Always pass through IDLE; start is not sampled here.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Status and results come straight from registers: no input-to-output path.
    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);
    assign out   = out_reg;
    assign shamt = shamt_reg;
    assign zero  = zero_reg;

endmodule
